sobel_row_loader: RTL and testbench
===================================

Name: sobel_row_loader

Overview:
- Upstream feeder for the sobel column array.
- Accepts a raster pixel stream, one pixel per beat, and assembles each image row of COLS pixels.
- Presents each completed row in parallel: one byte per column supplies current_in, and neighbouring bytes supply left_in/right_in.
- Two-row ping-pong buffering lets the next row fill while the array stalls on the current one.

Parameters:
COLS, 8, pixels per row (array width); must be >= 2.
ROWS, 8, rows per frame; must be >= 2.
PIX_W, 8, pixel width in bits.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
pix_in  input  PIX_W  raster pixel data
pix_valid  input  1  pix_in valid
pix_ready  output  1  loader can accept a pixel this cycle
row_out  output  COLS*PIX_W  assembled row; column c at bits [c*PIX_W +: PIX_W]
row_valid  output  1  row_out holds a complete row
row_ready  input  1  array consumes row this cycle
row_first  output  1  row_out is row 0 of the frame (qualified by row_valid)
row_last  output  1  row_out is row ROWS-1 of the frame (qualified by row_valid)
frame_done  output  1  one-cycle pulse after the final row of a frame is consumed

Behaviour:
- Reset: when rst=1 at a clock edge:
  - both banks are marked empty; col_cnt=0, fill_row=0, out_row=0; fill and output bank pointers = 0.
  - row_valid=0, frame_done=0, row_out=0.
  - pix_ready=1 from the first cycle after reset.
  - Reset mid-row or mid-frame discards all partial data; no row is emitted.
- Pixel accept: a pixel is accepted when pix_valid & pix_ready. pix_in is written to the fill bank at column col_cnt, then col_cnt increments.
- Row completion: accepting the pixel at col_cnt=COLS-1 marks the fill bank full, sets col_cnt=0 and toggles the fill pointer.
- Each bank's row index is latched from fill_row at completion. fill_row wraps from ROWS-1 to 0.
- pix_ready = fill bank not full (combinational from bank state). It is low only when both banks are full.
- Latency: row_valid rises on the clock edge that accepts the last pixel of a row, i.e. it is visible the next cycle when the output bank was empty.
- Output: row_out, row_first and row_last are driven from the output bank and are stable while row_valid=1 && row_ready=0.
- Output handshake: when row_valid & row_ready, the output bank is marked empty and the output pointer toggles.
  - If the other bank is already full, row_valid stays 1 and the next row appears on the following cycle with no bubble.
  - Sustained throughput is one row per COLS cycles.
- Simultaneous events: the last-pixel write and the row handshake in the same cycle are both honoured. A bank freed this cycle is not writable until the next cycle, so there is no same-cycle bank reuse.
- frame_done: registered pulse in the cycle after the handshake of a row with row_last=1.
- pix_valid=0 mid-row holds col_cnt; gaps of any length are allowed.
- row_out is zero-filled only at reset; banks are not cleared on consume.
- FSM per bank: EMPTY -> FILLING (first pixel) -> FULL (last pixel) -> EMPTY (handshake).

Optional Feature:
- Macro SOBEL_LOADER_FLUSH_EN.
- When defined:
  - After the row_last handshake, the loader emits 2 extra all-zero rows (row_first=0, row_last=0). These drain the array's X/Y intermediate pipeline.
  - frame_done pulses after the second flush row's handshake instead.
  - pix_ready is forced 0 while the flush is pending; the next frame's pixels are not accepted until the flush completes.
- When undefined: no flush rows; frame_done follows the row_last handshake directly.

Test Plan:
- Basic fill (defaults, row_ready=1): pixels 0x01..0x08 back-to-back -> row_valid=1 for 1 cycle, starting the cycle after the 8th accept; row_out=0x0807060504030201; row_first=1; row_last=0.
- Full frame: 64 pixels with value = index, row_ready=1 -> 8 row_valid pulses; row_last=1 on the 8th only; frame_done=1 one cycle after the 8th handshake.
- Backpressure: row_ready=0 while 24 pixels are offered -> pix_ready drops after the 16th accept; row_out holds row 0 unchanged; raising row_ready gives row 0 then row 1 on consecutive cycles, then pix_ready=1.
- Gapped input: pix_valid toggled 1/0 every cycle -> same row_out contents as the basic fill; row_valid after 8 accepts (15 cycles).
- Reset mid-row: 5 pixels, rst=1 for 1 cycle, then 8 pixels 0xA0..0xA7 -> first row_out=0xA7A6A5A4A3A2A1A0 with row_first=1; no prior partial row.
- With SOBEL_LOADER_FLUSH_EN: full frame -> 2 zero rows after row 7; pix_ready=0 during the flush; frame_done after the 2nd zero row.

Source files
------------

// File: rtl/sobel_row_loader.sv
// Raster-to-row loader for the sobel column array: two ping-pong row banks.
// Optional macro SOBEL_LOADER_FLUSH_EN appends two all-zero rows after each frame.
module sobel_row_loader #(
    parameter int unsigned COLS  = 8,
    parameter int unsigned ROWS  = 8,
    parameter int unsigned PIX_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIX_W-1:0]      pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [COLS*PIX_W-1:0] row_out,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic                  row_first,
    output logic                  row_last,
    output logic                  frame_done
);

    localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

    typedef enum logic [1:0] {StEmpty, StFilling, StFull} bank_state_e;

    bank_state_e      bank_state_q [2];
    bank_state_e      bank_state_d [2];
    logic [PIX_W-1:0] bank_data_q  [2][COLS];
    logic [RowW-1:0]  bank_row_q   [2];

    logic [ColW-1:0]  col_cnt_q;
    logic [RowW-1:0]  fill_row_q;
    logic             fill_ptr_q;
    logic             out_ptr_q;
    logic             frame_done_q;
    logic             frame_done_d;

    logic accept;
    logic last_pix;
    logic bank_valid;
    logic handshake;
    logic bank_pop;
    logic pop_last;
    logic flushing;

    assign accept     = pix_valid & pix_ready;
    assign last_pix   = accept & (col_cnt_q == LastCol);
    assign bank_valid = (bank_state_q[out_ptr_q] == StFull);
    assign row_valid  = bank_valid | flushing;
    assign handshake  = row_valid & row_ready;
    assign bank_pop   = handshake & ~flushing;
    assign pop_last   = bank_pop & (bank_row_q[out_ptr_q] == LastRow);
    assign pix_ready  = (bank_state_q[fill_ptr_q] != StFull) & ~flushing;
    assign frame_done = frame_done_q;

`ifdef SOBEL_LOADER_FLUSH_EN
    logic [1:0] flush_cnt_q;
    logic [1:0] flush_cnt_d;

    assign flushing = (flush_cnt_q != 2'd0);

    always_comb begin
        flush_cnt_d  = flush_cnt_q;
        frame_done_d = 1'b0;
        if (pop_last) begin
            flush_cnt_d = 2'd2;
        end else if (flushing && handshake) begin
            flush_cnt_d  = flush_cnt_q - 2'd1;
            frame_done_d = (flush_cnt_q == 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_q <= 2'd0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end
`else
    assign flushing = 1'b0;

    always_comb begin
        frame_done_d = pop_last;
    end
`endif

    // Flush rows override the bank contents with zeros and clear the frame markers.
    always_comb begin
        row_out = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            row_out[c*PIX_W +: PIX_W] = flushing ? '0 : bank_data_q[out_ptr_q][c];
        end
        row_first = ~flushing & (bank_row_q[out_ptr_q] == '0);
        row_last  = ~flushing & (bank_row_q[out_ptr_q] == LastRow);
    end

    // Fill and pop never target the same bank: a full fill bank blocks pix_ready.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_d[b] = bank_state_q[b];
            if (accept && (fill_ptr_q == 1'(b))) begin
                bank_state_d[b] = (col_cnt_q == LastCol) ? StFull : StFilling;
            end
            if (bank_pop && (out_ptr_q == 1'(b))) begin
                bank_state_d[b] = StEmpty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_q[b] <= StEmpty;
                bank_row_q[b]   <= '0;
                for (int c = 0; c < int'(COLS); c++) begin
                    bank_data_q[b][c] <= '0;
                end
            end
            col_cnt_q    <= '0;
            fill_row_q   <= '0;
            fill_ptr_q   <= 1'b0;
            out_ptr_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_state_q[b] <= bank_state_d[b];
            end
            if (accept) begin
                bank_data_q[fill_ptr_q][col_cnt_q] <= pix_in;
                if (last_pix) begin
                    col_cnt_q              <= '0;
                    fill_ptr_q             <= ~fill_ptr_q;
                    bank_row_q[fill_ptr_q] <= fill_row_q;
                    fill_row_q             <= (fill_row_q == LastRow) ? '0 : fill_row_q + 1'b1;
                end else begin
                    col_cnt_q <= col_cnt_q + 1'b1;
                end
            end
            if (bank_pop) begin
                out_ptr_q <= ~out_ptr_q;
            end
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_sobel_row_loader.sv
// Directed bench for sobel_row_loader at default parameters (8x8, 8-bit pixels).
module tb_sobel_row_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [63:0] row_out;
    logic        row_valid;
    logic        row_ready;
    logic        row_first;
    logic        row_last;
    logic        frame_done;

    sobel_row_loader #(.COLS(8), .ROWS(8), .PIX_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .row_out    (row_out),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_first  (row_first),
        .row_last   (row_last),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [63:0] data;
        logic        first;
        logic        last;
        logic        prdy;
        int          cyc;
    } hs_t;

    hs_t hs_q[$];
    int  n_vec   = 0;
    int  n_err   = 0;
    int  cyc     = 0;
    int  acc_cnt = 0;
    int  fd_cnt  = 0;
    int  fd_cyc  = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Logs the handshake and accept seen before the edge, then advances one clock.
    task automatic cycle();
        hs_t h;
        if (row_valid && row_ready) begin
            h.data  = row_out;
            h.first = row_first;
            h.last  = row_last;
            h.prdy  = pix_ready;
            h.cyc   = cyc;
            hs_q.push_back(h);
        end
        if (pix_valid && pix_ready) acc_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_in    = 8'h00;
        row_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        hs_q.delete();
        acc_cnt = 0;
        fd_cnt  = 0;
        fd_cyc  = -1;
    endtask

    initial begin
        logic [63:0] exp;
        int          n_rows;

        // Reset state
        do_reset();
        check("rst_row_valid", 64'(row_valid), 64'd0);
        check("rst_pix_ready", 64'(pix_ready), 64'd1);
        check("rst_row_out", row_out, 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);

        // Basic fill
        row_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("basic_pre_valid", 64'(row_valid), 64'd0);
            pix_valid = 1'b1;
            pix_in    = 8'(i + 1);
            cycle();
        end
        pix_valid = 1'b0;
        check("basic_valid", 64'(row_valid), 64'd1);
        check("basic_row_out", row_out, 64'h0807060504030201);
        check("basic_first_last", {62'd0, row_first, row_last}, 64'b10);
        cycle();
        check("basic_valid_drop", 64'(row_valid), 64'd0);
        check("basic_hs_count", 64'(hs_q.size()), 64'd1);

        // Full frame
        do_reset();
        row_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pix_valid = 1'b1;
            pix_in    = 8'(i);
            cycle();
        end
        pix_valid = 1'b0;
        repeat (6) cycle();
        check("frame_accepts", 64'(acc_cnt), 64'd64);
`ifdef SOBEL_LOADER_FLUSH_EN
        n_rows = 10;
`else
        n_rows = 8;
`endif
        check("frame_rows", 64'(hs_q.size()), 64'(n_rows));
        if (hs_q.size() == n_rows) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) exp[c*8 +: 8] = 8'(r * 8 + c);
                check($sformatf("frame_row%0d_data", r), hs_q[r].data, exp);
                check($sformatf("frame_row%0d_fl", r), {62'd0, hs_q[r].first, hs_q[r].last},
                      {62'd0, r == 0, r == 7});
            end
`ifdef SOBEL_LOADER_FLUSH_EN
            for (int r = 8; r < 10; r++) begin
                check($sformatf("flush_row%0d_data", r), hs_q[r].data, 64'd0);
                check($sformatf("flush_row%0d_fl", r), {62'd0, hs_q[r].first, hs_q[r].last},
                      64'd0);
                check($sformatf("flush_row%0d_prdy", r), 64'(hs_q[r].prdy), 64'd0);
            end
`endif
            check("frame_done_count", 64'(fd_cnt), 64'd1);
            check("frame_done_cycle", 64'(fd_cyc), 64'(hs_q[n_rows-1].cyc + 1));
        end

        // Backpressure
        do_reset();
        for (int k = 0; k < 24; k++) begin
            pix_valid = 1'b1;
            pix_in    = 8'(8'h10 + acc_cnt);
            cycle();
            if (k == 0) check("bp_first_valid_low", 64'(row_valid), 64'd0);
        end
        pix_valid = 1'b0;
        check("bp_accepts", 64'(acc_cnt), 64'd16);
        check("bp_pix_ready", 64'(pix_ready), 64'd0);
        check("bp_row_valid", 64'(row_valid), 64'd1);
        check("bp_hold_row0", row_out, 64'h1716151413121110);
        row_ready = 1'b1;
        cycle();
        cycle();
        check("bp_hs_count", 64'(hs_q.size()), 64'd2);
        if (hs_q.size() == 2) begin
            check("bp_row0", hs_q[0].data, 64'h1716151413121110);
            check("bp_row1", hs_q[1].data, 64'h1f1e1d1c1b1a1918);
            check("bp_row0_first", 64'(hs_q[0].first), 64'd1);
            check("bp_no_bubble", 64'(hs_q[1].cyc), 64'(hs_q[0].cyc + 1));
        end
        check("bp_drained_valid", 64'(row_valid), 64'd0);
        check("bp_pix_ready_back", 64'(pix_ready), 64'd1);

        // Gapped input
        do_reset();
        row_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            pix_valid = (k % 2 == 0);
            pix_in    = 8'(k / 2 + 1);
            if (k == 14) check("gap_pre_valid", 64'(row_valid), 64'd0);
            cycle();
        end
        pix_valid = 1'b0;
        check("gap_accepts", 64'(acc_cnt), 64'd8);
        check("gap_valid", 64'(row_valid), 64'd1);
        check("gap_row_out", row_out, 64'h0807060504030201);
        cycle();

        // Reset mid-row
        do_reset();
        row_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pix_valid = 1'b1;
            pix_in    = 8'h55;
            cycle();
        end
        pix_valid = 1'b0;
        rst       = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_valid", 64'(row_valid), 64'd0);
        hs_q.delete();
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1;
            pix_in    = 8'(8'hA0 + i);
            cycle();
        end
        pix_valid = 1'b0;
        cycle();
        check("mid_rst_rows", 64'(hs_q.size()), 64'd1);
        if (hs_q.size() >= 1) begin
            check("mid_rst_row_out", hs_q[0].data, 64'ha7a6a5a4a3a2a1a0);
            check("mid_rst_first", 64'(hs_q[0].first), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
